// File: rtl/ray_gen_camera.sv
// ray_gen_camera: pinhole-camera primary ray generator.
// Issues one six-word ray per pixel in raster order into the ray tracer input FIFO
// after a single start pulse. Directions are built incrementally (adds only).
// Optional feature macro: RAY_GEN_STALL_CNT_EN adds the 32-bit stall_cycles output.
module ray_gen_camera #(
   parameter int D_BITS = 32,
   parameter int Q_BITS = 10,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [2:0][D_BITS-1:0] cam_origin,
   input  logic [D_BITS-1:0]      pixel_step,
   input  logic [D_BITS-1:0]      focal,
   input  logic                   in_full,
   output logic                   in_wr_en,
   output logic [5:0][D_BITS-1:0] ray_out,
   output logic                   busy,
`ifdef RAY_GEN_STALL_CNT_EN
   output logic [31:0]            stall_cycles,
`endif
   output logic                   done
);

   localparam int XS = $clog2(IMG_W / 2);
   localparam int YS = $clog2(IMG_H / 2);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   // Reject configurations the counter wrap logic cannot represent.
   if ((IMG_W < 2) || (IMG_W != (1 << CW)) || (IMG_H < 2) || (IMG_H != (1 << RW)))
   begin : g_bad_img
      $error("IMG_W and IMG_H must be powers of two, at least 2");
   end
   if ((Q_BITS < 0) || (Q_BITS >= D_BITS)) begin : g_bad_q
      $error("Q_BITS must be smaller than D_BITS");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                 state_q;
   logic                   valid_q;
   logic [CW-1:0]          col_q;
   logic [RW-1:0]          row_q;
   logic [2:0][D_BITS-1:0] org_q;
   logic [D_BITS-1:0]      step_q;
   logic [D_BITS-1:0]      dx_q;
   logic [D_BITS-1:0]      dy_q;
   logic [D_BITS-1:0]      dz_q;
   logic [D_BITS-1:0]      dx0;
   logic                   accept;
   logic                   last_col;
   logic                   last_row;

   assign accept   = valid_q & ~in_full;
   assign in_wr_en = accept;
   assign last_col = (col_q == '1);
   assign last_row = (row_q == '1);
   // Left-most column direction, recomputed from the latched step on every row wrap.
   assign dx0      = -(step_q << XS);
   assign ray_out  = {dz_q, dy_q, dx_q, org_q};

   // Frame FSM, pixel counters and the registered ray words.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         org_q   <= '0;
         step_q  <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         dz_q    <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  org_q   <= cam_origin;
                  step_q  <= pixel_step;
                  dz_q    <= focal;
                  dx_q    <= -(pixel_step << XS);
                  dy_q    <= pixel_step << YS;
                  col_q   <= '0;
                  row_q   <= '0;
                  valid_q <= 1'b1;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               if (accept) begin
                  if (last_col && last_row) begin
                     col_q   <= '0;
                     row_q   <= '0;
                     valid_q <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state_q <= StDone;
                  end else if (last_col) begin
                     col_q <= '0;
                     row_q <= row_q + 1'b1;
                     dx_q  <= dx0;
                     dy_q  <= dy_q - step_q;
                  end else begin
                     col_q <= col_q + 1'b1;
                     dx_q  <= dx_q + step_q;
                  end
               end
            end
            StDone: begin
               done    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               valid_q <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

`ifdef RAY_GEN_STALL_CNT_EN
   // Saturating count of cycles a ray was ready but the FIFO was full.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if ((state_q == StIdle) && start) begin
         stall_cycles <= '0;
      end else if (valid_q && in_full && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ray_gen_camera.sv
// Self-checking bench for ray_gen_camera: closed-form per-pixel ray model,
// randomized backpressure and camera parameters, plus literal anchor values.
module tb_ray_gen_camera;

   localparam int W  = 32;
   localparam int H  = 32;
   localparam int N  = W * H;
   localparam int SX = $clog2(W / 2);
   localparam int SY = $clog2(H / 2);

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [2:0][31:0] cam_origin = '0;
   logic [31:0]      pixel_step = '0;
   logic [31:0]      focal = '0;
   logic             in_full = 1'b0;
   logic             in_wr_en;
   logic [5:0][31:0] ray_out;
   logic             busy;
   logic             done;
`ifdef RAY_GEN_STALL_CNT_EN
   logic [31:0]      stall_cycles;
`endif

   ray_gen_camera #(
      .D_BITS(32),
      .Q_BITS(10),
      .IMG_W (W),
      .IMG_H (H)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .cam_origin  (cam_origin),
      .pixel_step  (pixel_step),
      .focal       (focal),
      .in_full     (in_full),
      .in_wr_en    (in_wr_en),
      .ray_out     (ray_out),
      .busy        (busy),
`ifdef RAY_GEN_STALL_CNT_EN
      .stall_cycles(stall_cycles),
`endif
      .done        (done)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail = 0;
   int rays_seen = 0;
   int dones_seen = 0;
   int cyc = 0;
   int first_cyc = 0;
   int last_cyc = 0;
   int stall_exp = 0;
   int full_mode = 0;
   logic [31:0]      cfg_step = '0;
   logic [31:0]      cfg_focal = '0;
   logic [2:0][31:0] cfg_org = '0;
   logic [31:0]      cap_dx [N];
   logic [31:0]      cap_dy [N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Ray k of the frame: column k%W, row k/W; direction from pixel offset times step.
   function automatic logic [31:0] exp_word(input int k, input int w);
      logic [31:0] c;
      logic [31:0] r;
      c = 32'(k % W);
      r = 32'(k / W);
      case (w)
         0, 1, 2: return cfg_org[w];
         3:       return (32'd0 - (cfg_step << SX)) + cfg_step * c;
         4:       return (cfg_step << SY) - cfg_step * r;
         default: return cfg_focal;
      endcase
   endfunction

   always @(posedge clock) cyc <= cyc + 1;

   // Backpressure driver: none, every third cycle, or random.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (full_mode)
            0:       in_full = 1'b0;
            1:       in_full = ((cyc % 3) == 0);
            default: in_full = ($urandom_range(0, 3) == 0);
         endcase
      end
   end

   // Compare process: every accepted write is checked against the model.
   always @(negedge clock) begin
      if (!reset) begin
         if (busy && in_full) stall_exp++;
         if (in_wr_en) begin
            check("wr_while_full", {31'd0, in_full}, 32'd0);
            if (rays_seen < N) begin
               for (int w = 0; w < 6; w++) begin
                  check($sformatf("ray%0d_w%0d", rays_seen, w), ray_out[w],
                        exp_word(rays_seen, w));
               end
               cap_dx[rays_seen] = ray_out[3];
               cap_dy[rays_seen] = ray_out[4];
            end else begin
               check("extra_ray", rays_seen, N - 1);
            end
            if (rays_seen == 0) first_cyc = cyc;
            last_cyc = cyc;
            rays_seen++;
         end
         if (done) begin
            dones_seen++;
            check("done_after_all_rays", rays_seen, N);
         end
      end
   end

   task automatic start_frame(input logic [31:0] s, input logic [31:0] f,
                              input logic [31:0] o0, input logic [31:0] o1,
                              input logic [31:0] o2);
      cam_origin = {o2, o1, o0};
      pixel_step = s;
      focal      = f;
      cfg_org    = {o2, o1, o0};
      cfg_step   = s;
      cfg_focal  = f;
      rays_seen  = 0;
      dones_seen = 0;
      stall_exp  = 0;
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #3 start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("wr_en_after_start", {31'd0, in_wr_en}, {31'd0, ~in_full});
      for (int w = 0; w < 6; w++) begin
         check($sformatf("first_ray_w%0d", w), ray_out[w], exp_word(0, w));
      end
   endtask

   task automatic finish_frame(input int mode);
      for (int i = 0; i < 6000 && dones_seen == 0; i++) @(posedge clock);
      if (dones_seen == 0) check("done_timeout", dones_seen, 1);
      repeat (3) @(posedge clock);
      #3;
      check("frame_ray_count", rays_seen, N);
      check("frame_done_count", dones_seen, 1);
      check("busy_after_done", {31'd0, busy}, 32'd0);
      check("done_low_after", {31'd0, done}, 32'd0);
      if (mode == 0) check("consecutive_strobes", last_cyc - first_cyc + 1, N);
`ifdef RAY_GEN_STALL_CNT_EN
      check("stall_cycles", stall_cycles, stall_exp);
`endif
   endtask

   task automatic wait_rays(input int n);
      for (int i = 0; i < 4000 && rays_seen < n; i++) @(posedge clock);
      if (rays_seen < n) check("wait_rays_timeout", rays_seen, n);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_wr_en"}, {31'd0, in_wr_en}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      for (int w = 0; w < 6; w++) check($sformatf("%s_ray_w%0d", tag, w), ray_out[w], 32'd0);
   endtask

   initial begin
      #1 reset = 1'b1;
      #1 check_zero_outputs("reset");
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Scenario 1: unstalled reference frame, plus literal anchors.
      full_mode = 0;
      start_frame(32'h400, 32'h4000, 32'h0, 32'h0, 32'hFFFFD800);
      check("lit_first_dx", ray_out[3], 32'hFFFFC000);
      check("lit_first_dy", ray_out[4], 32'h00004000);
      check("lit_first_dz", ray_out[5], 32'h00004000);
      finish_frame(0);
      check("lit_ray1_dx", cap_dx[1], 32'hFFFFC400);
      check("lit_ray1023_dx", cap_dx[1023], 32'h00003C00);
      check("lit_ray1023_dy", cap_dy[1023], 32'hFFFFC400);
      check("lit_ray32_dx", cap_dx[32], 32'hFFFFC000);
      check("lit_ray32_dy", cap_dy[32], 32'h00003C00);

      // Scenario 2: full every third cycle.
      full_mode = 1;
      start_frame(32'h400, 32'h4000, 32'h0, 32'h0, 32'hFFFFD800);
      finish_frame(1);

      // Scenario 3: start pulse mid-frame with changed inputs is ignored.
      full_mode = 0;
      start_frame(32'h400, 32'h4000, 32'h0, 32'h0, 32'hFFFFD800);
      wait_rays(100);
      #1;
      start      = 1'b1;
      cam_origin = {$urandom, $urandom, $urandom};
      pixel_step = $urandom;
      focal      = $urandom;
      @(posedge clock);
      #1 start = 1'b0;
      finish_frame(0);

      // Scenario 4: reset mid-frame aborts, next start reissues from pixel (0,0).
      start_frame(32'h400, 32'h4000, 32'h0, 32'h0, 32'hFFFFD800);
      wait_rays(500);
      #1 reset = 1'b1;
      #1 check_zero_outputs("abort");
      @(posedge clock);
      #1 reset = 1'b0;
      start_frame(32'h400, 32'h4000, 32'h0, 32'h0, 32'hFFFFD800);
      check("lit_restart_dx", ray_out[3], 32'hFFFFC000);
      check("lit_restart_dy", ray_out[4], 32'h00004000);
      finish_frame(0);

      // Scenario 5: extreme step wraps by truncation, random backpressure.
      full_mode = 2;
      start_frame(32'h7FFFFFFF, $urandom, $urandom, $urandom, $urandom);
      check("lit_big_first_dx", ray_out[3], 32'h00000010);
      finish_frame(2);

      // Scenario 6: random camera settings with random backpressure.
      for (int f = 0; f < 2; f++) begin
         start_frame($urandom, $urandom, $urandom, $urandom, $urandom);
         finish_frame(2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ray_gen_camera.md
# ray_gen_camera

Pinhole-camera ray generator that produces one primary ray per pixel in raster order and pushes it into the ray tracer's input FIFO. It drives the write side of the ray input interface, which takes a six-word ray, an `in_wr_en` strobe and `in_full` backpressure. It replaces file-fed ray data with on-chip generation so a complete frame of IMG_W×IMG_H rays is issued from a single `start` pulse.

## Interface
- `D_BITS`, 32: ray word width, signed fixed point.
- `Q_BITS`, 10: fraction bits of all ray words.
- `IMG_W`, 32: image columns; power of two, at least 2.
- `IMG_H`, 32: image rows; power of two, at least 2.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle frame request; ignored unless IDLE.
- `cam_origin[2:0]`  in  D_BITS each  camera origin x/y/z, Q10.
- `pixel_step`  in  D_BITS  per-pixel direction increment, Q10.
- `focal`  in  D_BITS  direction z component, Q10.
- `in_full`  in  1  FIFO full from the ray tracer input.
- `in_wr_en`  out  1  ray write strobe.
- `ray_out[5:0]`  out  D_BITS each  [0..2] origin x/y/z, [3..5] direction x/y/z.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the final ray is accepted.

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when the last pixel is accepted.
  - DONE → IDLE unconditionally.
- On `start` in IDLE, latch `cam_origin`, `pixel_step` and `focal`. Input changes during a frame have no effect.
- Pixel counters `col` and `row` both start at 0.
  - `col` increments on each accepted write.
  - When `col` wraps from IMG_W-1 to 0, `row` increments.
- Direction is generated incrementally, with no multiplier:
  - dx0 = -(pixel_step << log2(IMG_W/2)).
  - dy0 = +(pixel_step << log2(IMG_H/2)).
  - dx += step on each accept; dx reloads dx0 on column wrap.
  - dy -= step on column wrap.
  - dz = focal always.
- Add/subtract is two's complement, truncated to D_BITS with no saturation. Q format is preserved: integer × Q10 step = Q10.
- Origin words equal the latched `cam_origin` for every ray.
- Accept: `in_wr_en = valid & ~in_full`, combinational from the registered `valid` and `in_full`. Counters advance only on accept.
- `ray_out` is registered and holds stable while `in_full` is high.
- `start` asserted in RUN or DONE is ignored; no queuing.
- `reset` asserted mid-frame aborts immediately and the FSM returns to IDLE. A partially issued frame is not resumed.

## Timing
Reset values of all outputs:
- `in_wr_en`=0, `busy`=0, `done`=0.
- `ray_out` all 0. Internal `valid`=0, `col`=`row`=0.

Latency and throughput:
- `start` sampled at edge N: `busy` and `valid` are high after edge N, and `ray_out` holds pixel (0,0). The earliest `in_wr_en` is in cycle N+1.
- One ray per cycle while `in_full` is low. An unstalled frame takes IMG_W·IMG_H consecutive `in_wr_en` cycles.
- A stall holds `ray_out`, `col` and `row` frozen. No ray is dropped or duplicated.
- The accept of pixel (IMG_W-1, IMG_H-1) at edge M clears `valid` and `busy`. `done`=1 during cycle M+1 only, then IDLE.
- A new `start` is accepted from the cycle after `done`.

## Configuration
- `RAY_GEN_STALL_CNT_EN` defined:
  - Adds output `stall_cycles` (32 bits).
  - It counts cycles with `valid & in_full`.
  - It clears on reset and on accepted `start`, saturates at 0xFFFFFFFF, and holds after DONE.
- Undefined: the port and counter are absent. The FSM and data behaviour are identical.

## Test plan
- Reset, then start with step=0x400, focal=0x4000, origin=(0,0,0xFFFFD800), `in_full`=0.
  - First ray: dir=(0xFFFFC000, 0x00004000, 0x00004000).
  - Ray 1: dx=0xFFFFC400.
  - Ray 1023: dir=(0x00003C00, 0xFFFFC400, 0x00004000).
  - Exactly 1024 strobes in 1024 consecutive cycles, then one `done` pulse.
- Same frame with `in_full` high on every third cycle.
  - 1024 strobes, none while full, sequence identical to the unstalled run.
  - With the macro defined, `stall_cycles` equals the number of full cycles that occurred while `valid`.
- Row wrap check: ray 32 has dx=0xFFFFC000 and dy=0x00003C00.
- `start` pulsed at ray 100: ignored. Frame count stays 1024 and one `done` only.
- `reset` asserted at ray 500:
  - Outputs zero asynchronously.
  - A following `start` reissues from pixel (0,0) with the first ray as in scenario 1.
- Step=0x7FFFFFFF with IMG_W=32: dx wraps by two's-complement truncation and no X values appear.
